// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and baud divisor helper.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_e;

  localparam int UART_DATA_BITS = 8;

  // Rounded clocks-per-bit.
  function automatic int baud_divisor(input int clock_rate, input int baud_rate);
    return (clock_rate + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two so pointers wrap for free.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign full_o     = (level_q == (AW+1)'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign level_o    = level_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes enter a FIFO over valid/ready and are sent back-to-back.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 100_000_000,
  parameter int BAUD_RATE  = 9_600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int DIVISOR = baud_divisor(CLOCK_RATE, BAUD_RATE);
  localparam int BW      = (DIVISOR < 2) ? 1 : $clog2(DIVISOR);

  generate
    if (DIVISOR < 2) begin : g_bad_divisor
      $error("uart_tx_buffered: DIVISOR must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_buffered: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  uart_tx_state_e             state_q, state_d;
  logic [BW-1:0]              baud_q, baud_d;
  logic [2:0]                 bit_q, bit_d;
  logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
  logic                       txd_q, txd_d;
  logic                       pop;
  logic [7:0]                 fifo_data;
  logic                       fifo_full, fifo_empty;
  logic                       baud_end;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (tx_valid),
    .push_data_i (tx_data),
    .pop_i       (pop),
    .pop_data_o  (fifo_data),
    .level_o     (fifo_level),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign baud_end = (baud_q == BW'(DIVISOR - 1));
  assign tx_ready = !fifo_full;
  assign tx_busy  = (state_q != IDLE) || !fifo_empty;
  assign txd      = txd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_data;
          txd_d   = 1'b0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          txd_d   = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'(UART_DATA_BITS - 1)) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
            txd_d   = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next START so buffered frames have no idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_data;
            txd_d   = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at 16 clocks per bit with a line monitor on txd.
module tb_uart_tx_buffered;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, txd, tx_busy;
  logic [3:0] fifo_level;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fe = 0;
  logic [7:0] rx_q[$];
  int         rx_t[$];

  uart_tx_buffered #(.CLOCK_RATE(100_000_000), .BAUD_RATE(6_250_000), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .txd(txd), .tx_busy(tx_busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: sample mid-bit, record byte, start cycle and framing errors.
  always begin : monitor
    int t0;
    logic [7:0] b;
    logic sb, sp;
    @(negedge clk);
    if (rst_n && txd === 1'b0) begin
      t0 = cyc;
      repeat (8) @(negedge clk);
      sb = txd;
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clk);
        b[i] = txd;
      end
      repeat (16) @(negedge clk);
      sp = txd;
      rx_q.push_back(b);
      rx_t.push_back(t0);
      if (sb !== 1'b0 || sp !== 1'b1) fe++;
      repeat (7) @(negedge clk);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic push_bytes(input logic [7:0] d [16], input int n,
                            output int first_edge, output int stalls);
    int idx = 0;
    int guard = 0;
    logic acc;
    first_edge = -1;
    stalls = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data = d[0];
    while (idx < n && guard < 20000) begin
      acc = tx_ready;
      if (!acc) stalls++;
      @(posedge clk); #1;
      if (acc) begin
        if (first_edge < 0) first_edge = cyc;
        idx++;
        if (idx < n) tx_data = d[idx];
      end
      guard++;
    end
    tx_valid = 1'b0;
    if (idx < n) begin
      checks++; errors++;
      $display("FAIL push_timeout accepted=%0d required=%0d", idx, n);
    end
  endtask

  task automatic wait_idle(output int t);
    int g = 0;
    @(negedge clk);
    while (tx_busy && g < 20000) begin
      @(negedge clk);
      g++;
    end
    t = cyc;
    if (tx_busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout busy=%0b required=0", tx_busy);
    end
  endtask

  task automatic test_reset;
    int edges = 0;
    repeat (3) @(negedge clk);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rst_txd got=%0b exp=1", txd); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%0b exp=1", tx_ready); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0b exp=0", tx_busy); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL rst_level got=%0d exp=0", fifo_level); end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (txd !== 1'b1 || tx_busy !== 1'b0) edges++;
    end
    checks++; if (edges !== 0) begin errors++; $display("FAIL idle_quiet got=%0d exp=0", edges); end
  endtask

  task automatic test_single_byte;
    logic [7:0] d [16];
    logic [7:0] v = 8'hA5;
    logic exp_txd;
    int n0, st;
    rx_q.delete(); rx_t.delete(); fe = 0;
    d[0] = 8'hA5;
    push_bytes(d, 1, n0, st);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL a5_edgeN got=%0b exp=1", txd); end
    for (int k = 1; k <= 161; k++) begin
      @(posedge clk); #1;
      if (k <= 16) exp_txd = 1'b0;
      else if (k <= 144) exp_txd = v[(k - 17) / 16];
      else exp_txd = 1'b1;
      checks++;
      if (txd !== exp_txd) begin errors++; $display("FAIL a5_wave k=%0d got=%0b exp=%0b", k, txd, exp_txd); end
      if (k == 160) begin
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL a5_busy160 got=%0b exp=1", tx_busy); end
      end
      if (k == 161) begin
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL a5_busy161 got=%0b exp=0", tx_busy); end
      end
    end
    checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL a5_count got=%0d exp=1", rx_q.size()); end
    else begin
      checks++; if (rx_q[0] !== 8'hA5) begin errors++; $display("FAIL a5_char got=%h exp=a5", rx_q[0]); end
    end
    checks++; if (fe !== 0) begin errors++; $display("FAIL a5_framing got=%0d exp=0", fe); end
  endtask

  task automatic test_burst;
    logic [7:0] d [16];
    int e0, st, t_end;
    rx_q.delete(); rx_t.delete(); fe = 0;
    for (int i = 0; i < 9; i++) d[i] = 8'(i);
    push_bytes(d, 9, e0, st);
    checks++; if (st !== 0) begin errors++; $display("FAIL burst_stalls got=%0d exp=0", st); end
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL burst_level got=%0d exp=8", fifo_level); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL burst_ready got=%0b exp=0", tx_ready); end
    wait_idle(t_end);
    checks++; if (rx_q.size() !== 9) begin errors++; $display("FAIL burst_count got=%0d exp=9", rx_q.size()); end
    else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (rx_q[i] !== 8'(i)) begin errors++; $display("FAIL burst_char i=%0d got=%h exp=%h", i, rx_q[i], 8'(i)); end
      end
      checks++; if (rx_t[0] !== e0 + 1) begin errors++; $display("FAIL burst_latency got=%0d exp=%0d", rx_t[0], e0 + 1); end
      checks++; if (rx_t[8] - rx_t[0] !== 1280) begin errors++; $display("FAIL burst_gap got=%0d exp=1280", rx_t[8] - rx_t[0]); end
      checks++; if (t_end - rx_t[0] !== 1440) begin errors++; $display("FAIL burst_span got=%0d exp=1440", t_end - rx_t[0]); end
    end
    checks++; if (fe !== 0) begin errors++; $display("FAIL burst_framing got=%0d exp=0", fe); end
  endtask

  task automatic test_backpressure;
    logic [7:0] d [16];
    int e0, st, t_end;
    rx_q.delete(); rx_t.delete(); fe = 0;
    d[0] = 8'h3A; d[1] = 8'hC5; d[2] = 8'h00; d[3]  = 8'hFF; d[4]  = 8'h81; d[5]  = 8'h7E;
    d[6] = 8'h42; d[7] = 8'h24; d[8] = 8'h99; d[9]  = 8'h66; d[10] = 8'h5A; d[11] = 8'hA5;
    push_bytes(d, 12, e0, st);
    checks++; if (st == 0) begin errors++; $display("FAIL bp_stalled got=%0d exp=>0", st); end
    wait_idle(t_end);
    checks++; if (rx_q.size() !== 12) begin errors++; $display("FAIL bp_count got=%0d exp=12", rx_q.size()); end
    else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (rx_q[i] !== d[i]) begin errors++; $display("FAIL bp_char i=%0d got=%h exp=%h", i, rx_q[i], d[i]); end
      end
    end
    checks++; if (fe !== 0) begin errors++; $display("FAIL bp_framing got=%0d exp=0", fe); end
  endtask

  task automatic test_same_edge;
    logic [7:0] d [16];
    int e0, st, t_end;
    rx_q.delete(); rx_t.delete(); fe = 0;
    d[0] = 8'h51; d[1] = 8'h52; d[2] = 8'h53; d[3] = 8'h54;
    push_bytes(d, 4, e0, st);
    while (cyc < e0 + 160) @(negedge clk);
    checks++; if (fifo_level !== 4'd3) begin errors++; $display("FAIL se_pre_level got=%0d exp=3", fifo_level); end
    tx_valid = 1'b1;
    tx_data = 8'h55;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    checks++; if (fifo_level !== 4'd3) begin errors++; $display("FAIL se_level got=%0d exp=3", fifo_level); end
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL se_start got=%0b exp=0", txd); end
    wait_idle(t_end);
    checks++; if (rx_q.size() !== 5) begin errors++; $display("FAIL se_count got=%0d exp=5", rx_q.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rx_q[i] !== 8'h51 + 8'(i)) begin errors++; $display("FAIL se_char i=%0d got=%h exp=%h", i, rx_q[i], 8'h51 + 8'(i)); end
      end
      checks++; if (rx_t[4] - rx_t[0] !== 640) begin errors++; $display("FAIL se_gap got=%0d exp=640", rx_t[4] - rx_t[0]); end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d [16];
    int e0, st, t_end;
    d[0] = 8'hFF; d[1] = 8'h11; d[2] = 8'h22;
    push_bytes(d, 3, e0, st);
    while (cyc < e0 + 88) @(negedge clk);
    checks++; if (fifo_level !== 4'd2) begin errors++; $display("FAIL rm_pre_level got=%0d exp=2", fifo_level); end
    rst_n = 1'b0;
    #1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rm_txd got=%0b exp=1", txd); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL rm_level got=%0d exp=0", fifo_level); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rm_busy got=%0b exp=0", tx_busy); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got=%0b exp=1", tx_ready); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (250) @(negedge clk);
    rx_q.delete(); rx_t.delete(); fe = 0;
    d[0] = 8'h3C;
    push_bytes(d, 1, e0, st);
    wait_idle(t_end);
    checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL rm_count got=%0d exp=1", rx_q.size()); end
    else begin
      checks++; if (rx_q[0] !== 8'h3C) begin errors++; $display("FAIL rm_char got=%h exp=3c", rx_q[0]); end
    end
    checks++; if (fe !== 0) begin errors++; $display("FAIL rm_framing got=%0d exp=0", fe); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_backpressure();
    test_same_edge();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
